// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: extends instr[31:7] per select and buffers results in a 2-entry queue.
// Optional per-entry illegal-select flag on out_err is enabled by defining IMM_ERR_FLAG_EN.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_ERR_FLAG_EN
  ,
  output logic             out_err
`endif
);

  // Indexed with full-instruction bit numbers so the extension table reads like the ISA manual.
  logic [31:7]      ins_s;
  logic [XLEN-1:0]  ext_imm_s;
  logic             push_s;
  logic             pop_s;

  logic [1:0]       count_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [XLEN-1:0]  imm_mem_r [2];
  logic [TAG_W-1:0] tag_mem_r [2];
`ifdef IMM_ERR_FLAG_EN
  logic             err_s;
  logic             err_mem_r [2];
`endif

  assign ins_s     = in_instr;
  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Immediate extension by select; illegal select yields zero.
  always_comb begin
    ext_imm_s = {XLEN{1'b0}};
    case (in_src)
      3'b000: ext_imm_s = {{(XLEN-12){ins_s[31]}}, ins_s[31:20]};
      3'b001: ext_imm_s = {{(XLEN-12){ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
      3'b010: ext_imm_s = {{(XLEN-13){ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25],
                           ins_s[11:8], 1'b0};
      3'b011: ext_imm_s = {{(XLEN-21){ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20],
                           ins_s[30:21], 1'b0};
      // Sign-extend the 20-bit field first, then shift; upper XLEN-32 bits track instr[31].
      3'b100: ext_imm_s = {{(XLEN-20){ins_s[31]}}, ins_s[31:12]} << 5'd12;
      3'b101: ext_imm_s = {{(XLEN-5){1'b0}}, ins_s[19:15]};
      3'b110: begin
        if (XLEN == 64) begin
          ext_imm_s = {{(XLEN-6){1'b0}}, ins_s[25:20]};
        end else begin
          ext_imm_s = {{(XLEN-5){1'b0}}, ins_s[24:20]};
        end
      end
      default: ext_imm_s = {XLEN{1'b0}};
    endcase
  end

`ifdef IMM_ERR_FLAG_EN
  assign err_s = (in_src == 3'b111);
`endif

  // Queue pointers, occupancy and storage; flush drops any concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_mem_r[i] <= {XLEN{1'b0}};
        tag_mem_r[i] <= {TAG_W{1'b0}};
`ifdef IMM_ERR_FLAG_EN
        err_mem_r[i] <= 1'b0;
`endif
      end
    end else if (flush) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        imm_mem_r[wr_ptr_r] <= ext_imm_s;
        tag_mem_r[wr_ptr_r] <= in_tag;
`ifdef IMM_ERR_FLAG_EN
        err_mem_r[wr_ptr_r] <= err_s;
`endif
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign out_imm = imm_mem_r[rd_ptr_r];
  assign out_tag = tag_mem_r[rd_ptr_r];
`ifdef IMM_ERR_FLAG_EN
  assign out_err = err_mem_r[rd_ptr_r];
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances, extension table, queue handshake, flush, reset.
module tb_imm_extend_pipe;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             flush, in_valid, out_ready, in_ready, out_valid;
  logic [24:0]      in_instr;
  logic [2:0]       in_src;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [31:0]      out_imm;

  logic             flush64, in_valid64, out_ready64, in_ready64, out_valid64;
  logic [24:0]      in_instr64;
  logic [2:0]       in_src64;
  logic [TAG_W-1:0] in_tag64, out_tag64;
  logic [63:0]      out_imm64;
`ifdef IMM_ERR_FLAG_EN
  logic             out_err, out_err64;
`endif

  int checks = 0;
  int failures = 0;

  imm_extend_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_src(in_src), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
`ifdef IMM_ERR_FLAG_EN
    , .out_err(out_err)
`endif
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_instr(in_instr64), .in_src(in_src64), .in_tag(in_tag64), .out_valid(out_valid64),
    .out_ready(out_ready64), .out_imm(out_imm64), .out_tag(out_tag64)
`ifdef IMM_ERR_FLAG_EN
    , .out_err(out_err64)
`endif
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive32(input logic [31:0] instr, input logic [2:0] src, input logic [3:0] tag);
    in_instr = instr[31:7];
    in_src   = src;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Push one entry with out_ready low, check it one cycle later, then pop it.
  task automatic xfer32(input string name, input logic [31:0] instr, input logic [2:0] src,
                        input logic [31:0] exp);
    drive32(instr, src, 4'h1);
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk(name, {32'd0, out_imm}, {32'd0, exp});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_popped"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 25'd0; in_src = 3'd0; in_tag = 4'd0;
    flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0;
    in_instr64 = 25'd0; in_src64 = 3'd0; in_tag64 = 4'd0;
    step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_imm", {32'd0, out_imm}, 64'd0);
    chk("rst_tag", {60'd0, out_tag}, 64'd0);
    chk("rst_valid64", {63'd0, out_valid64}, 64'd0);
    chk("rst_imm64", out_imm64, 64'd0);
    rst_n = 1'b1;
    step();

    // Extension table, XLEN=32
    xfer32("i_neg1",  32'hFFF00093, 3'b000, 32'hFFFFFFFF);
    xfer32("i_pos",   32'h7FF00093, 3'b000, 32'h000007FF);
    xfer32("s_sw",    32'hFE512E23, 3'b001, 32'hFFFFFFFC);
    xfer32("b_p8",    32'h00000463, 3'b010, 32'h00000008);
    xfer32("j_m4",    32'hFFDFF06F, 3'b011, 32'hFFFFFFFC);
    xfer32("u_lui",   32'h12345037, 3'b100, 32'h12345000);
    xfer32("z_zimm",  32'h800F8000, 3'b101, 32'h0000001F);
    xfer32("sh_32",   32'h03F00013, 3'b110, 32'h0000001F);
    xfer32("illegal", 32'hFFFFFFFF, 3'b111, 32'h00000000);

`ifdef IMM_ERR_FLAG_EN
    drive32(32'hFFFFFFFF, 3'b111, 4'h2);
    step();
    drive32(32'hFFF00093, 3'b000, 4'h3);
    step();
    in_valid = 1'b0;
    chk("err_set", {63'd0, out_err}, 64'd1);
    chk("err_imm", {32'd0, out_imm}, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("err_clear", {63'd0, out_err}, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif

    // Back-pressure: three consecutive pushes with out_ready low
    drive32(32'h00100093, 3'b000, 4'hA);
    step();
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    drive32(32'h00200093, 3'b000, 4'hB);
    step();
    chk("bp_ready2", {63'd0, in_ready}, 64'd0);
    chk("bp_head_tag", {60'd0, out_tag}, 64'hA);
    drive32(32'h00300093, 3'b000, 4'hC);
    step();
    in_valid = 1'b0;
    chk("bp_ready3", {63'd0, in_ready}, 64'd0);
    chk("bp_stable_tag", {60'd0, out_tag}, 64'hA);
    chk("bp_stable_imm", {32'd0, out_imm}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("drain_tag2", {60'd0, out_tag}, 64'hB);
    chk("drain_imm2", {32'd0, out_imm}, 64'd2);
    step();
    out_ready = 1'b0;
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // Simultaneous push/pop at count 1
    drive32(32'h00400093, 3'b000, 4'hD);
    step();
    drive32(32'h00500093, 3'b000, 4'hE);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_valid", {63'd0, out_valid}, 64'd1);
    chk("pp_tag", {60'd0, out_tag}, 64'hE);
    chk("pp_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("pp_empty", {63'd0, out_valid}, 64'd0);

    // out_ready high while empty must not drop the incoming entry
    drive32(32'h00600093, 3'b000, 4'hF);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("empty_rdy_valid", {63'd0, out_valid}, 64'd1);
    chk("empty_rdy_tag", {60'd0, out_tag}, 64'hF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Flush at count 2 with a concurrent push
    drive32(32'h00700093, 3'b000, 4'h7);
    step();
    drive32(32'h00800093, 3'b000, 4'h8);
    step();
    chk("fl_full", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    drive32(32'h00900093, 3'b000, 4'h9);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("fl_lost", {63'd0, out_valid}, 64'd0);
    drive32(32'h00A00093, 3'b000, 4'h3);
    step();
    in_valid = 1'b0;
    chk("fl_after_tag", {60'd0, out_tag}, 64'h3);
    chk("fl_after_imm", {32'd0, out_imm}, 64'd10);

    // XLEN=64: U sign extension and 6-bit shamt, queued back to back
    in_instr64 = 25'h1000000; // 0x80000037 >> 7
    in_src64 = 3'b100; in_tag64 = 4'h4; in_valid64 = 1'b1;
    step();
    in_instr64 = 25'h007E000; // 0x03F00013 >> 7
    in_src64 = 3'b110; in_tag64 = 4'h5;
    step();
    in_valid64 = 1'b0;
    chk("u64", out_imm64, 64'hFFFFFFFF80000000);
    chk("u64_tag", {60'd0, out_tag64}, 64'h4);
    out_ready64 = 1'b1;
    step();
    chk("sh64", out_imm64, 64'd63);
    step();
    out_ready64 = 1'b0;
    chk("sh64_empty", {63'd0, out_valid64}, 64'd0);

    // Asynchronous reset mid-stream (dut32 still holds tag 3)
    drive32(32'hFFF00093, 3'b000, 4'h5);
    step();
    in_valid = 1'b0;
    chk("mid_valid_pre", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_imm", {32'd0, out_imm}, 64'd0);
    chk("mid_rst_tag", {60'd0, out_tag}, 64'd0);
`ifdef IMM_ERR_FLAG_EN
    chk("mid_rst_err", {63'd0, out_err}, 64'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
